display_arbiter: RTL and testbench

Schedules the shared 7-segment display path between three producers: live operand entry, computation result and error. Picks the winning source by priority and minimum-hold rules, drives the external `bcd_convert` instance through a start/done handshake, and presents only fully converted, stable values to the display driver. Sits between the calculator core and the display driver.

---
 rtl/display_pkg.sv | 36 +++
 rtl/display_arbiter_hold_timer.sv | 38 +++
 rtl/display_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_display_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
//   Shared types and constants for the display arbitration path.
//   - state_t    : display_arbiter FSM states
//   - src_t      : source code presented on disp_src to the display driver
//   - SYM_*      : nibble codes the display driver renders as symbols
//   - cnt_width  : width of a down-counter able to hold the value n-1
// -----------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOAD        = 3'd1,
        CONVERT     = 3'd2,
        SHOW_RESULT = 3'd3,
        ERROR       = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SRC_ENTRY  = 2'd0,
        SRC_RESULT = 2'd1,
        SRC_ERROR  = 2'd2
    } src_t;

    // Non-decimal nibbles reserved for symbols, so they never collide with BCD.
    localparam logic [3:0] SYM_E     = 4'hE;
    localparam logic [3:0] SYM_R     = 4'hA;
    localparam logic [3:0] SYM_O     = 4'hB;
    localparam logic [3:0] SYM_EMPTY = 4'hF;

    // Bits needed to hold n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/display_arbiter_hold_timer.sv
// -----------------------------------------------------------------------------
// hold_timer
//   Loadable down-counter that stops at zero. Used both for the minimum result
//   hold time and for the converter timeout.
//   Ports:
//     clock       in  : system clock
//     reset_n     in  : synchronous active-low reset (count -> 0)
//     load        in  : load load_value this cycle (wins over counting)
//     load_value  in  : value to load
//     zero        out : count has reached zero (stays there until reloaded)
// -----------------------------------------------------------------------------
module hold_timer
    import display_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/display_arbiter.sv
// -----------------------------------------------------------------------------
// display_arbiter
//   Arbitrates the shared 7-segment display path between live operand entry,
//   computation results and errors. The winning value is sent through an
//   external bcd_convert via a start/done handshake; only completed
//   conversions reach the display.
//   Ports:
//     clock, reset_n             : 50 MHz clock, synchronous active-low reset
//     entry_value   in  WIDTH    : operand being typed (level)
//     result_req    in           : pulse, result_value valid
//     result_value  in  WIDTH    : new result
//     error_req     in           : pulse, calculator error
//     clear         in           : pulse, drop error/result, back to entry
//     conv_start    out          : pulse to converter
//     conv_binary   out WIDTH    : converter operand, stable while converting
//     conv_bcd      in  WIDTH    : converter result, valid with conv_done
//     conv_done     in           : pulse from converter
//     disp_value    out WIDTH    : BCD value shown
//     disp_error    out          : show the error message
//     disp_src      out 2        : 0=ENTRY 1=RESULT 2=ERROR
//     busy          out          : conversion in flight
//     fault         out          : sticky converter timeout
// -----------------------------------------------------------------------------
module display_arbiter
    import display_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int HOLD_CYCLES  = 25_000_000,
    parameter int CONV_TIMEOUT = 1024
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] entry_value,
    input  logic             result_req,
    input  logic [WIDTH-1:0] result_value,
    input  logic             error_req,
    input  logic             clear,
    output logic             conv_start,
    output logic [WIDTH-1:0] conv_binary,
    input  logic [WIDTH-1:0] conv_bcd,
    input  logic             conv_done,
    output logic [WIDTH-1:0] disp_value,
    output logic             disp_error,
    output logic [1:0]       disp_src,
    output logic             busy,
    output logic             fault
);

    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int TMO_W  = cnt_width(CONV_TIMEOUT);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_INIT  = TMO_W'(CONV_TIMEOUT - 1);

    state_t           state_q, state_d;
    src_t             target_q, target_d;
    src_t             disp_src_q, disp_src_d;
    logic [WIDTH-1:0] last_entry, last_entry_d;
    logic             pend_vld, pend_vld_d;
    logic [WIDTH-1:0] pend_value, pend_value_d;
    logic [WIDTH-1:0] conv_binary_d;
    logic [WIDTH-1:0] disp_value_d;
    logic             disp_error_d;
    logic             fault_d;

    // Request that won arbitration this cycle and starts a new conversion.
    logic             go_load;
    logic [WIDTH-1:0] go_value;
    src_t             go_target;

    logic             hold_load, hold_zero;
    logic             to_load, conv_expired;
    logic             entry_changed;

    assign entry_changed = (entry_value != last_entry);

    // LOAD always exits after one cycle, so state_d==LOAD marks entry into it.
    assign to_load = (state_d == LOAD);

    hold_timer #(.CNT_W(HOLD_W)) u_hold_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (hold_load),
        .load_value (HOLD_INIT),
        .zero       (hold_zero)
    );

    // Loaded as conv_start issues; expiring means CONV_TIMEOUT-1 cycles
    // have elapsed since the start pulse without an answer.
    hold_timer #(.CNT_W(TMO_W)) u_timeout_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (to_load),
        .load_value (TMO_INIT),
        .zero       (conv_expired)
    );

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        disp_src_d    = disp_src_q;
        last_entry_d  = last_entry;
        pend_vld_d    = pend_vld;
        pend_value_d  = pend_value;
        conv_binary_d = conv_binary;
        disp_value_d  = disp_value;
        disp_error_d  = disp_error;
        fault_d       = fault;
        hold_load     = 1'b0;
        go_load       = 1'b0;
        go_value      = entry_value;
        go_target     = SRC_ENTRY;

        if (error_req) begin
            // Error preempts everything, including a conv_done this cycle.
            state_d      = ERROR;
            disp_error_d = 1'b1;
            disp_src_d   = SRC_ERROR;
            pend_vld_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (result_req) begin
                        go_load   = 1'b1;
                        go_value  = result_value;
                        go_target = SRC_RESULT;
                    end else if (entry_changed) begin
                        go_load      = 1'b1;
                        last_entry_d = entry_value;
                    end
                end

                LOAD: begin
                    state_d = CONVERT;
                    // conv_start already went out; a new result must wait.
                    if (result_req) begin
                        pend_vld_d   = 1'b1;
                        pend_value_d = result_value;
                    end
                end

                CONVERT: begin
                    if (conv_done) begin
                        disp_value_d = conv_bcd;
                        disp_src_d   = target_q;
                        if (result_req) begin
                            go_load    = 1'b1;
                            go_value   = result_value;
                            go_target  = SRC_RESULT;
                            pend_vld_d = 1'b0;
                        end else if (pend_vld) begin
                            go_load    = 1'b1;
                            go_value   = pend_value;
                            go_target  = SRC_RESULT;
                            pend_vld_d = 1'b0;
                        end else if (target_q == SRC_RESULT) begin
                            state_d   = SHOW_RESULT;
                            hold_load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (conv_expired) begin
                        state_d      = ERROR;
                        fault_d      = 1'b1;
                        disp_error_d = 1'b1;
                        disp_src_d   = SRC_ERROR;
                        pend_vld_d   = 1'b0;
                    end else if (result_req) begin
                        // One-deep: the newest result overwrites an older one.
                        pend_vld_d   = 1'b1;
                        pend_value_d = result_value;
                    end
                end

                SHOW_RESULT: begin
                    if (clear) begin
                        go_load      = 1'b1;
                        last_entry_d = entry_value;
                    end else if (result_req) begin
                        go_load   = 1'b1;
                        go_value  = result_value;
                        go_target = SRC_RESULT;
                    end else if (hold_zero && entry_changed) begin
                        go_load      = 1'b1;
                        last_entry_d = entry_value;
                    end
                end

                ERROR: begin
                    if (clear) begin
                        go_load      = 1'b1;
                        last_entry_d = entry_value;
                        disp_error_d = 1'b0;
                    end
                end

                default: state_d = IDLE;
            endcase

            if (go_load) begin
                state_d       = LOAD;
                conv_binary_d = go_value;
                target_d      = go_target;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            target_q    <= SRC_ENTRY;
            disp_src_q  <= SRC_ENTRY;
            last_entry  <= '0;
            pend_vld    <= 1'b0;
            pend_value  <= '0;
            conv_binary <= '0;
            disp_value  <= '0;
            disp_error  <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            disp_src_q  <= disp_src_d;
            last_entry  <= last_entry_d;
            pend_vld    <= pend_vld_d;
            pend_value  <= pend_value_d;
            conv_binary <= conv_binary_d;
            disp_value  <= disp_value_d;
            disp_error  <= disp_error_d;
            fault       <= fault_d;
        end
    end

    assign conv_start = (state_q == LOAD);
    assign busy       = (state_q == LOAD) || (state_q == CONVERT);
    assign disp_src   = disp_src_q;

endmodule

// File: tb/tb_display_arbiter.sv
module tb_display_arbiter;
    import display_pkg::*;

    localparam int WIDTH = 32;
    localparam int HOLD  = 8;
    localparam int TMO   = 16;

    typedef struct packed {
        logic [WIDTH-1:0] value;
        logic [1:0]       src;
    } disp_exp_t;

    logic             clock;
    logic             reset_n;
    logic [WIDTH-1:0] entry_value;
    logic             result_req;
    logic [WIDTH-1:0] result_value;
    logic             error_req;
    logic             clear;
    logic             conv_start;
    logic [WIDTH-1:0] conv_binary;
    logic [WIDTH-1:0] conv_bcd;
    logic             conv_done;
    logic [WIDTH-1:0] disp_value;
    logic             disp_error;
    logic [1:0]       disp_src;
    logic             busy;
    logic             fault;

    display_arbiter #(
        .WIDTH        (WIDTH),
        .HOLD_CYCLES  (HOLD),
        .CONV_TIMEOUT (TMO)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .entry_value  (entry_value),
        .result_req   (result_req),
        .result_value (result_value),
        .error_req    (error_req),
        .clear        (clear),
        .conv_start   (conv_start),
        .conv_binary  (conv_binary),
        .conv_bcd     (conv_bcd),
        .conv_done    (conv_done),
        .disp_value   (disp_value),
        .disp_error   (disp_error),
        .disp_src     (disp_src),
        .busy         (busy),
        .fault        (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_conv[$];
    disp_exp_t        exp_disp[$];
    logic [WIDTH-1:0] shown;
    int               nstarts;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for conv_start, then compare conv_binary with the oldest
    // expected operand.
    task automatic wait_start(input string tag, input int limit);
        int n;
        logic [WIDTH-1:0] e;
        n = 0;
        while (conv_start !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        if (conv_start !== 1'b1) begin
            check({tag, "_start"}, 32'(conv_start), 32'd1);
            if (exp_conv.size() > 0) void'(exp_conv.pop_front());
        end else if (exp_conv.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_unexpected_start observed=%0h expected=none", tag, conv_binary);
        end else begin
            e = exp_conv.pop_front();
            check({tag, "_binary"}, conv_binary, e);
        end
    endtask

    task automatic count_starts(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (conv_start === 1'b1) cnt++;
        end
    endtask

    task automatic do_done(input string tag, input logic [WIDTH-1:0] bcd,
                           input logic [1:0] src);
        disp_exp_t e;
        exp_disp.push_back('{value: bcd, src: src});
        conv_bcd  = bcd;
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        e = exp_disp.pop_front();
        check({tag, "_disp_value"}, disp_value, e.value);
        check({tag, "_disp_src"}, 32'(disp_src), 32'(e.src));
        shown = e.value;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_conv_start"},  32'(conv_start), 32'd0);
        check({tag, "_conv_binary"}, conv_binary,     32'd0);
        check({tag, "_disp_value"},  disp_value,      32'd0);
        check({tag, "_disp_error"},  32'(disp_error), 32'd0);
        check({tag, "_disp_src"},    32'(disp_src),   32'd0);
        check({tag, "_busy"},        32'(busy),       32'd0);
        check({tag, "_fault"},       32'(fault),      32'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        entry_value  = '0;
        result_req   = 1'b0;
        result_value = '0;
        error_req    = 1'b0;
        clear        = 1'b0;
        conv_bcd     = '0;
        conv_done    = 1'b0;
        shown        = '0;

        // Reset state, then idle with entry 0: nothing to convert.
        tick(); tick(); tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        count_starts(5, nstarts);
        check("idle_no_start", 32'(nstarts), 32'd0);

        // Entry 123: one start next cycle, display after done.
        entry_value = 32'd123;
        exp_conv.push_back(32'd123);
        tick();
        check("entry_start_latency", 32'(conv_start), 32'd1);
        wait_start("entry123", 0);
        check("entry_busy_load", 32'(busy), 32'd1);
        tick();
        check("entry_start_pulse", 32'(conv_start), 32'd0);
        check("entry_busy_conv", 32'(busy), 32'd1);
        tick();
        do_done("entry123", 32'h123, SRC_ENTRY);
        check("entry_busy_done", 32'(busy), 32'd0);
        count_starts(3, nstarts);
        check("entry_single_start", 32'(nstarts), 32'd0);

        // Result arrives while the entry conversion is running.
        entry_value = 32'd77;
        exp_conv.push_back(32'd77);
        tick();
        wait_start("entry77", 2);
        tick();
        result_req   = 1'b1;
        result_value = 32'd4567;
        exp_conv.push_back(32'd4567);
        tick();
        result_req = 1'b0;
        tick();
        do_done("entry77", 32'h77, SRC_ENTRY);
        wait_start("pending4567", 0);
        tick();
        do_done("result4567", 32'h4567, SRC_RESULT);
        // Entry edits during the hold wait until it expires.
        entry_value = 32'd55;
        exp_conv.push_back(32'd55);
        count_starts(HOLD - 1, nstarts);
        check("hold_blocks_entry", 32'(nstarts), 32'd0);
        check("hold_disp_src", 32'(disp_src), 32'd1);
        tick();
        check("hold_expire_start", 32'(conv_start), 32'd1);
        wait_start("entry55", 0);
        tick();
        do_done("entry55", 32'h55, SRC_ENTRY);

        // Error during CONVERT, stale done ignored, clear converts entry.
        entry_value = 32'd9;
        exp_conv.push_back(32'd9);
        tick();
        wait_start("entry9", 2);
        tick();
        error_req = 1'b1;
        tick();
        error_req = 1'b0;
        check("err_disp_error", 32'(disp_error), 32'd1);
        check("err_disp_src", 32'(disp_src), 32'd2);
        check("err_busy", 32'(busy), 32'd0);
        conv_bcd  = 32'h999;
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        check("err_late_done", disp_value, shown);
        check("err_holds", 32'(disp_error), 32'd1);
        entry_value = 32'd31;
        exp_conv.push_back(32'd31);
        tick();
        check("err_ignores_entry", 32'(conv_start), 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_disp_error", 32'(disp_error), 32'd0);
        wait_start("clear31", 0);
        tick();
        do_done("entry31", 32'h31, SRC_ENTRY);

        // conv_done and error_req together: error wins.
        entry_value = 32'd42;
        exp_conv.push_back(32'd42);
        tick();
        wait_start("entry42", 2);
        tick();
        conv_bcd  = 32'h42;
        conv_done = 1'b1;
        error_req = 1'b1;
        tick();
        conv_done = 1'b0;
        error_req = 1'b0;
        check("tie_disp_value", disp_value, shown);
        check("tie_disp_error", 32'(disp_error), 32'd1);
        check("tie_disp_src", 32'(disp_src), 32'd2);
        exp_conv.push_back(32'd42);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        wait_start("clear42", 0);
        tick();
        do_done("entry42", 32'h42, SRC_ENTRY);

        // Converter never answers.
        entry_value = 32'd1000;
        exp_conv.push_back(32'd1000);
        tick();
        wait_start("entry1000", 2);
        for (int i = 0; i < TMO - 1; i++) tick();
        check("timeout_early_fault", 32'(fault), 32'd0);
        tick();
        check("timeout_fault", 32'(fault), 32'd1);
        check("timeout_disp_error", 32'(disp_error), 32'd1);
        check("timeout_disp_src", 32'(disp_src), 32'd2);
        exp_conv.push_back(32'd1000);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("fault_sticky", 32'(fault), 32'd1);
        wait_start("clear1000", 0);
        tick();
        do_done("entry1000", 32'h1000, SRC_ENTRY);

        // Reset while busy; late done afterwards is ignored.
        entry_value = 32'd5;
        exp_conv.push_back(32'd5);
        tick();
        wait_start("entry5", 2);
        tick();
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset_n     = 1'b0;
        entry_value = '0;
        tick();
        check_reset_outputs("mid_reset");
        reset_n = 1'b1;
        tick();
        conv_bcd  = 32'h777;
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        check("stale_done_disp", disp_value, 32'd0);
        check("stale_done_busy", 32'(busy), 32'd0);
        count_starts(4, nstarts);
        check("stale_done_no_start", 32'(nstarts), 32'd0);

        check("scoreboard_conv_left", 32'(exp_conv.size()), 32'd0);
        check("scoreboard_disp_left", 32'(exp_disp.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
